// File: rtl/spi_memory_fsm.sv
// spi_memory_fsm: SPI memory transaction controller.
// Counts conditioned SCLK edges inside a chip-select frame and issues the
// address-latch, shift-register-load, memory-write and MISO-enable controls.
module spi_memory_fsm #(
    parameter int unsigned ADDR_BITS = 7,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic sclk_fall,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_en,
    output logic busy
);

    localparam int unsigned HDR_BITS = ADDR_BITS + 1;
    localparam int unsigned MAX_CNT  = (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
    localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HDR_TC  = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_BITS);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             rw_q, rw_next;

    // Next-state and counter logic; chip-select release overrides everything.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rw_next    = rw_q;
        if (state != IDLE && cs_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_n) state_next = GET_ADDR;
                end
                GET_ADDR: begin
                    if (cnt == HDR_TC)  state_next = GOT_ADDR;
                    else if (sclk_rise) cnt_next = cnt + CNT_W'(1);
                end
                GOT_ADDR: begin
                    rw_next    = rw_bit;
                    state_next = rw_bit ? READ_WAIT : WRITE_SHIFT;
                end
                READ_WAIT: state_next = READ_LOAD;
                READ_LOAD: state_next = READ_SHIFT;
                READ_SHIFT: begin
                    if (cnt == DATA_TC) state_next = DONE;
                    else if (sclk_fall) cnt_next = cnt + CNT_W'(1);
                end
                WRITE_SHIFT: begin
                    if (cnt == DATA_TC) state_next = WRITE_COMMIT;
                    else if (sclk_rise) cnt_next = cnt + CNT_W'(1);
                end
                WRITE_COMMIT: state_next = DONE;
                DONE: state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
        // Every state entry starts with a clean count.
        if (state_next != state) cnt_next = '0;
    end

    // State, counter, rw latch and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            addr_we <= 1'b0;
            sr_we   <= 1'b0;
            dm_we   <= 1'b0;
            miso_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rw_q    <= rw_next;
            addr_we <= (state_next == GOT_ADDR);
            sr_we   <= (state_next == READ_LOAD);
            dm_we   <= (state_next == WRITE_COMMIT);
            miso_en <= (state_next == READ_SHIFT);
            busy    <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Bench for spi_memory_fsm: frame-level table, directed corner sequences and
// random stimulus, all checked cycle by cycle against a timeline model.
module tb_spi_memory_fsm;

    localparam int HDR       = 8;
    localparam int DATA_BITS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n = 1'b1;
    logic sclk_rise = 1'b0;
    logic sclk_fall = 1'b0;
    logic rw_bit = 1'b0;
    logic addr_we, sr_we, dm_we, miso_en, busy;

    always #5 clk = ~clk;

    spi_memory_fsm #(.ADDR_BITS(7), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .rw_bit(rw_bit),
        .addr_we(addr_we), .sr_we(sr_we), .dm_we(dm_we),
        .miso_en(miso_en), .busy(busy)
    );

    // Model: frame activity, header edge tally, then a cycle timeline t
    // (t=0 is the address strobe cycle) with a data-edge tally and the
    // timeline point fin where the data phase ended.
    typedef struct {
        bit act;
        bit rd;
        int hdr;
        int t;
        int dcnt;
        int fin;
    } mdl_t;

    typedef struct {
        bit rd;
        int abort_at;
        bit noise;
        int gap;
        int e_addr;
        int e_sr;
        int e_dm;
        int e_miso;
    } vec_t;

    mdl_t m;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_addr = 0, n_sr = 0, n_dm = 0, n_miso = 0;
    int   addr_t = 0, sr_t = 0, dm_t = 0, miso_last = 0;
    int   last_pulse = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.act = 0; r.rd = 0; r.hdr = 0; r.t = -1; r.dcnt = 0; r.fin = -1;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t cur, logic c, logic r, logic f, logic w);
        mdl_t n;
        int   dstart;
        n = cur;
        if (!cur.act) begin
            if (!c) begin
                n = mdl_reset();
                n.act = 1;
            end
        end else if (c) begin
            n.act = 0;
        end else if (cur.t < 0) begin
            if (cur.hdr == HDR) n.t = 0;
            else if (r)         n.hdr = cur.hdr + 1;
        end else begin
            if (cur.t == 0) n.rd = w;
            n.t = cur.t + 1;
            dstart = n.rd ? 3 : 1;
            if (cur.t >= dstart && cur.fin < 0) begin
                if (cur.dcnt == DATA_BITS)   n.fin = cur.t + 1;
                else if (n.rd ? f : r)       n.dcnt = cur.dcnt + 1;
            end
        end
        return n;
    endfunction

    // Expected {addr_we, sr_we, dm_we, miso_en, busy}.
    function automatic logic [4:0] expect_out(mdl_t cur);
        logic [4:0] e;
        e = 5'b0;
        if (cur.act) begin
            e[0] = 1'b1;
            if (cur.t >= 0) begin
                e[4] = (cur.t == 0);
                e[3] = cur.rd && (cur.t == 2);
                e[2] = !cur.rd && (cur.fin >= 0) && (cur.t == cur.fin);
                e[1] = cur.rd && (cur.t >= 3) && (cur.fin < 0);
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: advance model at posedge, compare and monitor at negedge.
    task automatic tick();
        logic [4:0] got, want;
        @(posedge clk);
        cyc++;
        if (!rst_n) m = mdl_reset();
        else        m = step(m, cs_n, sclk_rise, sclk_fall, rw_bit);
        @(negedge clk);
        got  = {addr_we, sr_we, dm_we, miso_en, busy};
        want = expect_out(m);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL model cyc=%0d got=%b want=%b", cyc, got, want);
        end
        if (addr_we) begin n_addr++; addr_t = cyc; end
        if (sr_we)   begin n_sr++;   sr_t = cyc;   end
        if (dm_we)   begin n_dm++;   dm_t = cyc;   end
        if (miso_en) begin n_miso++; miso_last = cyc; end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one frame: 8 header rises, then 8 data edges (falls for read).
    task automatic run_frame(input vec_t v);
        bit aborted;
        aborted = 0;
        cs_n = 1'b0;
        tick();
        for (int k = 1; k <= HDR + DATA_BITS; k++) begin
            rw_bit = (k >= HDR) ? v.rd : 1'($urandom_range(0, 1));
            if (k <= HDR || !v.rd) sclk_rise = 1'b1;
            else                   sclk_fall = 1'b1;
            last_pulse = cyc;
            if (k == v.abort_at) begin
                cs_n = 1'b1;
                aborted = 1;
            end
            tick();
            sclk_rise = 1'b0;
            sclk_fall = 1'b0;
            if (aborted) break;
            for (int j = 0; j < 2; j++) begin
                sclk_fall = v.noise && (k < HDR);
                sclk_rise = v.noise && v.rd && (k > HDR);
                tick();
                sclk_rise = 1'b0;
                sclk_fall = 1'b0;
            end
            if (k == HDR) ticks(5);
        end
        if (!aborted) begin
            ticks(3);
            cs_n = 1'b1;
        end
        ticks(v.gap);
    endtask

    vec_t tbl[8];

    initial begin
        int a0, s0, d0, mi0;
        logic [4:0] outs;
        tbl[0] = '{0, 0,  0, 2, 1, 0, 1, 0};
        tbl[1] = '{1, 0,  0, 2, 1, 1, 0, 1};
        tbl[2] = '{0, 16, 0, 2, 1, 0, 0, 0};
        tbl[3] = '{0, 4,  0, 2, 0, 0, 0, 0};
        tbl[4] = '{1, 12, 0, 2, 1, 1, 0, 1};
        tbl[5] = '{0, 0,  1, 1, 1, 0, 1, 0};
        tbl[6] = '{0, 0,  0, 1, 1, 0, 1, 0};
        tbl[7] = '{1, 0,  1, 2, 1, 1, 0, 1};
        m = mdl_reset();

        // Reset held with an active frame and free-running edges.
        rst_n = 1'b0;
        cs_n  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk_rise = 1'($urandom_range(0, 1));
            sclk_fall = 1'($urandom_range(0, 1));
            tick();
            outs = {addr_we, sr_we, dm_we, miso_en, busy};
            check("reset_outputs", int'(outs), 0);
        end
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        rst_n = 1'b1;
        tick();
        check("busy_after_release", int'(busy), 1);
        cs_n = 1'b1;
        ticks(2);

        // Frame table.
        for (int i = 0; i < 8; i++) begin
            a0 = n_addr; s0 = n_sr; d0 = n_dm; mi0 = n_miso;
            run_frame(tbl[i]);
            check($sformatf("v%0d_addr_we", i), n_addr - a0, tbl[i].e_addr);
            check($sformatf("v%0d_sr_we", i),   n_sr - s0,   tbl[i].e_sr);
            check($sformatf("v%0d_dm_we", i),   n_dm - d0,   tbl[i].e_dm);
            check($sformatf("v%0d_miso_seen", i), int'(n_miso > mi0), tbl[i].e_miso);
            if (tbl[i].e_sr != 0)
                check($sformatf("v%0d_sr_delay", i), sr_t - addr_t, 2);
            if (tbl[i].e_dm != 0)
                check($sformatf("v%0d_dm_time", i), dm_t - last_pulse, 2);
            if (tbl[i].rd && tbl[i].abort_at == 0)
                check($sformatf("v%0d_miso_end", i), miso_last - last_pulse, 1);
        end

        // Reset asserted mid-read-shift: no strobe after release.
        cs_n = 1'b0;
        tick();
        for (int k = 0; k < HDR; k++) begin
            rw_bit = 1'b1;
            sclk_rise = 1'b1;
            tick();
            sclk_rise = 1'b0;
            tick();
        end
        ticks(6);
        check("miso_before_reset", int'(miso_en), 1);
        rst_n = 1'b0;
        #1;
        outs = {addr_we, sr_we, dm_we, miso_en, busy};
        check("async_reset_outputs", int'(outs), 0);
        tick();
        cs_n = 1'b1;
        rst_n = 1'b1;
        d0 = n_dm; a0 = n_addr;
        ticks(4);
        check("no_strobe_after_reset", (n_dm - d0) + (n_addr - a0), 0);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 119) == 0) cs_n = ~cs_n;
            rst_n     = ($urandom_range(0, 599) != 0);
            sclk_rise = ($urandom_range(0, 3) == 0);
            sclk_fall = ($urandom_range(0, 3) == 0);
            rw_bit    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
